// File: rtl/cp0_timer_if.sv
// Local register window bus for the CP0 timer block.
interface cp0_timer_if;
    logic        wen;
    logic [3:0]  waddr;
    logic [63:0] wdata;
    logic [3:0]  raddr;
    logic [63:0] rdata;

    modport master (
        output wen, waddr, wdata, raddr,
        input  rdata
    );

    modport slave (
        input  wen, waddr, wdata, raddr,
        output rdata
    );
endinterface

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer with Random/Wired TLB index generator.
// Define CP0_TIMER_PERIODIC_EN to add per-channel auto-reload Period registers.
module cp0_timer #(
    parameter int COUNT_W = 32,
    parameter int NCMP    = 1,
    parameter int DIV     = 2,
    parameter int TLBENT  = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      phi2_i,
    input  logic                      stall_i,
    cp0_timer_if.slave                bus,
    output logic [NCMP-1:0]           timer_irq_o,
    output logic [COUNT_W-1:0]        count_o,
    output logic [$clog2(TLBENT)-1:0] random_o
);

    localparam int RW = $clog2(TLBENT);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [RW-1:0] RAND_TOP = RW'(TLBENT - 1);

    logic [DW-1:0]      div_q, div_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [COUNT_W-1:0] cmp_q [NCMP];
    logic [COUNT_W-1:0] cmp_d [NCMP];
    logic [NCMP-1:0]    pend_q, pend_d;
    logic [RW-1:0]      wired_q, wired_d;
    logic [RW-1:0]      rand_q, rand_d;
    logic [NCMP-1:0]    hit;
    logic [15:0]        wsel;
    logic               unused_bits;

`ifdef CP0_TIMER_PERIODIC_EN
    logic [COUNT_W-1:0] per_q [NCMP];
    logic [COUNT_W-1:0] per_d [NCMP];
`endif

    // One-hot write select; already qualified by phi2
    assign wsel = (phi2_i && bus.wen) ? (16'b1 << bus.waddr) : 16'b0;
    assign unused_bits = ^{bus.wdata, wsel};

    always_comb begin
        div_d   = div_q;
        count_d = count_q;
        if (wsel[0]) begin
            count_d = bus.wdata[COUNT_W-1:0];
            div_d   = '0;
        end else if (phi2_i) begin
            if (div_q == DIV_LAST) begin
                div_d   = '0;
                count_d = count_q + COUNT_W'(1);
            end else begin
                div_d = div_q + DW'(1);
            end
        end
    end

    always_comb begin
        hit    = '0;
        pend_d = pend_q;
        for (int k = 0; k < NCMP; k++) begin
            hit[k]   = (count_q == cmp_q[k]);
            cmp_d[k] = cmp_q[k];
`ifdef CP0_TIMER_PERIODIC_EN
            per_d[k] = per_q[k];
            if (phi2_i && hit[k] && per_q[k] != '0)
                cmp_d[k] = cmp_q[k] + per_q[k];
            if (wsel[8+k])
                per_d[k] = bus.wdata[COUNT_W-1:0];
`endif
            if (phi2_i && hit[k])
                pend_d[k] = 1'b1;
            // Explicit writes override a same-cycle match
            if (wsel[4+k]) begin
                cmp_d[k]  = bus.wdata[COUNT_W-1:0];
                pend_d[k] = 1'b0;
            end
            if (wsel[3] && bus.wdata[k])
                pend_d[k] = 1'b0;
        end
    end

    always_comb begin
        wired_d = wired_q;
        rand_d  = rand_q;
        if (wsel[1]) begin
            wired_d = bus.wdata[RW-1:0];
            rand_d  = RAND_TOP;
        end else if (phi2_i && !stall_i) begin
            if (rand_q == wired_q || rand_q == '0)
                rand_d = RAND_TOP;
            else
                rand_d = rand_q - RW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= '0;
            count_q <= '0;
            pend_q  <= '0;
            wired_q <= '0;
            rand_q  <= RAND_TOP;
            for (int k = 0; k < NCMP; k++) begin
                cmp_q[k] <= '1;
`ifdef CP0_TIMER_PERIODIC_EN
                per_q[k] <= '0;
`endif
            end
        end else begin
            div_q   <= div_d;
            count_q <= count_d;
            pend_q  <= pend_d;
            wired_q <= wired_d;
            rand_q  <= rand_d;
            for (int k = 0; k < NCMP; k++) begin
                cmp_q[k] <= cmp_d[k];
`ifdef CP0_TIMER_PERIODIC_EN
                per_q[k] <= per_d[k];
`endif
            end
        end
    end

    always_comb begin
        bus.rdata = '0;
        case (bus.raddr)
            4'd0:    bus.rdata = 64'(count_q);
            4'd1:    bus.rdata = 64'(wired_q);
            4'd2:    bus.rdata = 64'(rand_q);
            4'd3:    bus.rdata = 64'(pend_q);
            default: bus.rdata = '0;
        endcase
        for (int k = 0; k < NCMP; k++) begin
            if (bus.raddr == 4'(4 + k))
                bus.rdata = 64'(cmp_q[k]);
`ifdef CP0_TIMER_PERIODIC_EN
            if (bus.raddr == 4'(8 + k))
                bus.rdata = 64'(per_q[k]);
`endif
        end
    end

    assign timer_irq_o = pend_q;
    assign count_o     = count_q;
    assign random_o    = rand_q;

endmodule

// File: tb/tb_cp0_timer.sv
// Randomized and directed bench for cp0_timer against a behavioural model.
module tb_cp0_timer;
    localparam int CW = 8;
    localparam int NC = 2;
    localparam int DV = 2;
    localparam int TE = 32;
    localparam int RW = 5;
    localparam int CMOD = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          phi2 = 1'b0;
    logic          stall = 1'b0;
    logic [NC-1:0] irq;
    logic [CW-1:0] cnt;
    logic [RW-1:0] rnd;

    cp0_timer_if bus();

    cp0_timer #(
        .COUNT_W(CW), .NCMP(NC), .DIV(DV), .TLBENT(TE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .phi2_i(phi2), .stall_i(stall),
        .bus(bus), .timer_irq_o(irq), .count_o(cnt), .random_o(rnd)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: plain integers, modulo arithmetic
    int          m_ticks;
    int          m_cnt;
    int          m_cmp [NC];
    int          m_per [NC];
    bit [NC-1:0] m_pend;
    int          m_wired;
    int          m_rand;

    task automatic m_reset();
        m_ticks = 0;
        m_cnt   = 0;
        m_pend  = '0;
        m_wired = 0;
        m_rand  = TE - 1;
        for (int k = 0; k < NC; k++) begin
            m_cmp[k] = CMOD - 1;
            m_per[k] = 0;
        end
    endtask

    function automatic logic [63:0] m_read(int a);
        if (a == 0) return 64'(m_cnt);
        if (a == 1) return 64'(m_wired);
        if (a == 2) return 64'(m_rand);
        if (a == 3) return 64'(m_pend);
        if (a >= 4 && a < 4 + NC) return 64'(m_cmp[a-4]);
`ifdef CP0_TIMER_PERIODIC_EN
        if (a >= 8 && a < 8 + NC) return 64'(m_per[a-8]);
`endif
        return 64'd0;
    endfunction

    task automatic m_step(bit p, bit s, bit w, int a, logic [63:0] d);
        bit [NC-1:0] match;
        int lo;
        if (!p) return;
        lo = int'(d[CW-1:0]);
        for (int k = 0; k < NC; k++) match[k] = (m_cnt == m_cmp[k]);
        if (w && a == 0) begin
            m_cnt   = lo;
            m_ticks = 0;
        end else begin
            m_ticks = m_ticks + 1;
            if (m_ticks % DV == 0) begin
                m_ticks = 0;
                m_cnt = (m_cnt + 1) % CMOD;
            end
        end
        for (int k = 0; k < NC; k++) begin
            if (match[k]) m_pend[k] = 1'b1;
`ifdef CP0_TIMER_PERIODIC_EN
            if (match[k] && m_per[k] != 0)
                m_cmp[k] = (m_cmp[k] + m_per[k]) % CMOD;
            if (w && a == 8 + k) m_per[k] = lo;
`endif
            if (w && a == 4 + k) begin
                m_cmp[k]  = lo;
                m_pend[k] = 1'b0;
            end
            if (w && a == 3 && d[k]) m_pend[k] = 1'b0;
        end
        if (w && a == 1) begin
            m_wired = int'(d[RW-1:0]);
            m_rand  = TE - 1;
        end else if (!s) begin
            if (m_rand == m_wired || m_rand == 0) m_rand = TE - 1;
            else m_rand = m_rand - 1;
        end
    endtask

    // One clock: drive at negedge, compare pre-edge state, advance model
    task automatic cyc(bit p, bit s, bit w, int wa, logic [63:0] d, int ra);
        @(negedge clk);
        phi2      = p;
        stall     = s;
        bus.wen   = w;
        bus.waddr = wa[3:0];
        bus.wdata = d;
        bus.raddr = ra[3:0];
        #1;
        check("rdata", bus.rdata, m_read(ra));
        check("irq", 64'(irq), 64'(m_pend));
        check("count", 64'(cnt), 64'(m_cnt));
        check("random", 64'(rnd), 64'(m_rand));
        @(posedge clk);
        m_step(p, s, w, wa, d);
        #1;
    endtask

    task automatic wr(int a, logic [63:0] d);
        cyc(1'b1, 1'b0, 1'b1, a, d, a);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++)
            cyc(1'b1, 1'b0, 1'b0, 0, 64'd0, int'($urandom_range(0, 15)));
    endtask

    int rseq [4] = '{30, 29, 28, 31};
    int c0;
    bit seen;

    initial begin
        bus.wen = 1'b0;
        bus.waddr = '0;
        bus.wdata = '0;
        bus.raddr = 4'd4;
        m_reset();
        #12;
        check("rst_count", 64'(cnt), 64'd0);
        check("rst_random", 64'(rnd), 64'd31);
        check("rst_irq", 64'(irq), 64'd0);
        check("rst_cmp0", bus.rdata, 64'hff);
        @(negedge clk);
        rst_n = 1'b1;

        idle(10);
        check("div_count", 64'(cnt), 64'd5);

        wr(4, 64'd8);
        wr(0, 64'd5);
        idle(6);
        check("irq_early", 64'(irq[0]), 64'd0);
        idle(1);
        check("irq_rise", 64'(irq[0]), 64'd1);
        idle(3);
        check("irq_sticky", 64'(irq[0]), 64'd1);
        wr(3, 64'd1);
        check("irq_w1c", 64'(irq[0]), 64'd0);
        wr(0, 64'd8);
        wr(4, 64'd8);
        check("cmpwr_wins", 64'(irq[0]), 64'd0);
        idle(1);
        check("rematch", 64'(irq[0]), 64'd1);
        wr(3, 64'd3);

        wr(1, 64'd28);
        check("wired_rand", 64'(rnd), 64'd31);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            check("rand_seq", 64'(rnd), 64'(rseq[i]));
        end
        c0 = int'(cnt);
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 1'b1, 1'b0, 0, 64'd0, 2);
        check("stall_rand", 64'(rnd), 64'd31);
        check("stall_count", 64'(cnt), 64'((c0 + 2) % CMOD));
        c0 = int'(cnt);
        cyc(1'b0, 1'b0, 1'b1, 0, 64'h33, 0);
        check("nophi2_wr", 64'(cnt), 64'(c0));

        wr(4, 64'h80);
        wr(5, 64'd0);
        wr(3, 64'd3);
        wr(0, 64'hff);
        idle(1);
        check("wrap_ff", 64'(cnt), 64'hff);
        idle(1);
        check("wrap_0", 64'(cnt), 64'd0);
        check("wrap_noirq", 64'(irq), 64'd0);
        idle(1);
        check("ch1_only", 64'(irq), 64'd2);

`ifdef CP0_TIMER_PERIODIC_EN
        wr(3, 64'd3);
        wr(8, 64'd10);
        wr(4, 64'd10);
        wr(0, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 0, 64'd0, 4);
            seen = irq[0];
        end
        check("per_wait1", 64'(seen), 64'd1);
        check("per_cmp20", bus.rdata, 64'd20);
        wr(3, 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 0, 64'd0, 4);
            seen = irq[0];
        end
        check("per_wait2", 64'(seen), 64'd1);
        check("per_cmp30", bus.rdata, 64'd30);
`else
        wr(8, 64'h55);
        cyc(1'b1, 1'b0, 1'b0, 0, 64'd0, 8);
        check("no_period", bus.rdata, 64'd0);
`endif

        for (int i = 0; i < 3000; i++) begin
            bit p, s, w;
            int wa;
            logic [63:0] d;
            p  = ($urandom_range(0, 3) != 0);
            s  = ($urandom_range(0, 4) == 0);
            w  = ($urandom_range(0, 3) == 0);
            wa = int'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) wa = int'($urandom_range(0, 5));
            d  = {$urandom, $urandom};
            if (wa >= 4 && $urandom_range(0, 1) == 1)
                d = 64'((m_cnt + int'($urandom_range(0, 6))) % CMOD);
            cyc(p, s, w, wa, d, int'($urandom_range(0, 15)));
        end

        wr(3, 64'd3);
        wr(4, 64'h40);
        wr(0, 64'h40);
        idle(1);
        check("pre_rst_irq", 64'(irq[0]), 64'd1);
        @(negedge clk);
        phi2 = 1'b0;
        bus.wen = 1'b0;
        bus.raddr = 4'd4;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_count", 64'(cnt), 64'd0);
        check("async_random", 64'(rnd), 64'd31);
        check("async_irq", 64'(irq), 64'd0);
        check("async_cmp0", bus.rdata, 64'hff);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
